alu_shift_seq: RTL and testbench

Iterative shift sequencer for the ALU shift path. It accepts one SLL/SRL/SRA request at a time over a valid/ready handshake and produces the shifted result several cycles later. It replaces a full combinational barrel shifter with a shift-by-one step repeated per clock. It sits beside the combinational ALU in the execute stage and serves multi-cycle shift operations for the core; the result must bit-match the single-cycle `alu_sra`/`alu_srl`/`alu_sll` semantics.

---
 rtl/alu_shift_seq.sv | 149 ++++++++++++++
 tb/tb_alu_shift_seq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_shift_seq.sv
// Iterative SLL/SRL/SRA sequencer: one shift step per clock over valid/ready.
// Optional ALU_SHIFT_SEQ_FAST4_EN: shift by 4 per step while cnt >= 4.
module alu_shift_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [SHAMT_W-1:0] CNT_ZERO = '0;
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

  state_e             state_q, state_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]    rd_q, rd_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;

  logic [XLEN-1:0]    step1;
  logic [XLEN-1:0]    step_res;
  logic [SHAMT_W-1:0] step_amt;
  logic [SHAMT_W-1:0] rs2_amt;
  logic               accept;
  logic               unused_rs2_hi;

  assign rs2_amt       = rs2[SHAMT_W-1:0];
  assign unused_rs2_hi = ^rs2[XLEN-1:SHAMT_W];

  always_comb begin
    step1 = acc_q;
    unique case (op_q)
      OP_SLL:  step1 = {acc_q[XLEN-2:0], 1'b0};
      OP_SRL:  step1 = {1'b0, acc_q[XLEN-1:1]};
      OP_SRA:  step1 = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: step1 = acc_q;
    endcase
  end

`ifdef ALU_SHIFT_SEQ_FAST4_EN
  localparam logic [SHAMT_W-1:0] CNT_FOUR = SHAMT_W'(4);

  logic [XLEN-1:0] step4;

  always_comb begin
    step4 = acc_q;
    unique case (op_q)
      OP_SLL:  step4 = {acc_q[XLEN-5:0], 4'b0000};
      OP_SRL:  step4 = {4'b0000, acc_q[XLEN-1:4]};
      OP_SRA:  step4 = {{4{acc_q[XLEN-1]}}, acc_q[XLEN-1:4]};
      default: step4 = acc_q;
    endcase
  end

  always_comb begin
    step_res = step1;
    step_amt = CNT_ONE;
    if (cnt_q >= CNT_FOUR) begin
      step_res = step4;
      step_amt = CNT_FOUR;
    end
  end
`else
  assign step_res = step1;
  assign step_amt = CNT_ONE;
`endif

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = rs1;
          cnt_d = rs2_amt;
          op_d  = op;
          if (rs2_amt != CNT_ZERO && op != OP_RSV) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            rd_d    = rs1;
          end
        end
      end
      SHIFT: begin
        acc_d = step_res;
        cnt_d = cnt_q - step_amt;
        // Last step lands the result straight into rd
        if (cnt_q == step_amt) begin
          state_d = DONE;
          rd_d    = step_res;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == DONE);
  assign rd         = rd_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench for alu_shift_seq against an arithmetic shift model.
// Define ALU_SHIFT_SEQ_FAST4_EN for both RTL and bench to test the fast path.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] rd;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_shift_seq #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .rd         (rd),
    .busy       (busy)
  );

  function automatic logic [31:0] ref_rd(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    int k;
    k = int'(b[4:0]);
    case (o)
      2'b00:   return a << k;
      2'b01:   return a >> k;
      2'b10:   return $unsigned($signed(a) >>> k);
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o,
                                 input logic [31:0] b);
    int k;
    k = int'(b[4:0]);
    if (o == 2'b11) return 0;
`ifdef ALU_SHIFT_SEQ_FAST4_EN
    return k / 4 + k % 4;
`else
    return k;
`endif
  endfunction

  // Issues one request from a negedge with the DUT idle; returns at a negedge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit release_resp,
                        output logic [31:0] r, output int lat,
                        output int bad);
    bad = 0;
    lat = 0;
    req_valid = 1'b1;
    op = o;
    rs1 = a;
    rs2 = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    op = 2'($urandom);
    rs1 = $urandom;
    rs2 = $urandom;
    @(negedge clk);
    while (resp_valid !== 1'b1 && lat < 64) begin
      if (busy !== 1'b1 || req_ready !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    r = rd;
    if (busy !== 1'b1 || req_ready !== 1'b0) bad++;
    if (release_resp) begin
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req_ready got=%b exp=0", req_ready);
    end
    n_vec++;
    if (resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_resp_valid got=%b exp=0", resp_valid);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rd got=%h exp=00000000", rd);
    end
    req_valid = 1'b1;
    op = 2'b00;
    rs1 = 32'h5;
    rs2 = 32'h3;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vs_req_busy got=%b exp=0", busy);
    end
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle got rdy=%b busy=%b exp rdy=1 busy=0",
               req_ready, busy);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  t_op[9];
    logic [31:0] t_a[9];
    logic [31:0] t_b[9];
    logic [31:0] r;
    int lat;
    int bad;
    t_op[0] = 2'b10; t_a[0] = 32'hFFFFFFFE; t_b[0] = 32'd1;
    t_op[1] = 2'b10; t_a[1] = 32'h00000002; t_b[1] = 32'd1;
    t_op[2] = 2'b01; t_a[2] = 32'hFFFFFFFF; t_b[2] = 32'd1;
    t_op[3] = 2'b10; t_a[3] = 32'hFFFFFFFF; t_b[3] = 32'd1;
    t_op[4] = 2'b00; t_a[4] = 32'h00000001; t_b[4] = 32'd31;
    t_op[5] = 2'b00; t_a[5] = 32'hA5A5_1234; t_b[5] = 32'd0;
    t_op[6] = 2'b10; t_a[6] = 32'h80000000; t_b[6] = 32'h00000021;
    t_op[7] = 2'b11; t_a[7] = 32'h12345678; t_b[7] = 32'd7;
    t_op[8] = 2'b01; t_a[8] = 32'h80000000; t_b[8] = 32'd31;
    for (int i = 0; i < 9; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 1'b1, r, lat, bad);
      n_vec++;
      if (r !== ref_rd(t_op[i], t_a[i], t_b[i])) begin
        n_err++;
        $display("FAIL dir%0d_rd got=%h exp=%h", i, r,
                 ref_rd(t_op[i], t_a[i], t_b[i]));
      end
      n_vec++;
      if (lat !== ref_lat(t_op[i], t_b[i])) begin
        n_err++;
        $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat,
                 ref_lat(t_op[i], t_b[i]));
      end
      n_vec++;
      if (bad !== 0) begin
        n_err++;
        $display("FAIL dir%0d_busy_ready got=%0d bad cycles exp=0", i, bad);
      end
      n_vec++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir%0d_idle got rdy=%b busy=%b vld=%b exp 1 0 0",
                 i, req_ready, busy, resp_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    int lat;
    int bad;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      run_op(o, a, b, 1'b1, r, lat, bad);
      n_vec++;
      if (r !== ref_rd(o, a, b) || lat !== ref_lat(o, b) || bad !== 0) begin
        n_err++;
        $display("FAIL rand%0d op=%0d a=%h b=%h got rd=%h lat=%0d bad=%0d exp rd=%h lat=%0d bad=0",
                 i, o, a, b, r, lat, bad, ref_rd(o, a, b), ref_lat(o, b));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] r;
    logic [31:0] held;
    int lat;
    int bad;
    run_op(2'b10, 32'hF0000000, 32'd3, 1'b0, r, lat, bad);
    held = 32'hFE000000;
    n_vec++;
    if (r !== held) begin
      n_err++;
      $display("FAIL bp_first_rd got=%h exp=%h", r, held);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid = 1'b1;
        op = 2'b00;
        rs1 = 32'h1;
        rs2 = 32'h4;
      end
      @(negedge clk);
      req_valid = 1'b0;
      n_vec++;
      if (resp_valid !== 1'b1 || rd !== held || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d got vld=%b rd=%h rdy=%b exp 1 %h 0",
                 i, resp_valid, rd, req_ready, held);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    n_vec++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release got vld=%b rdy=%b busy=%b exp 0 1 0",
               resp_valid, req_ready, busy);
    end
    run_op(2'b00, 32'h3, 32'd2, 1'b1, r, lat, bad);
    n_vec++;
    if (r !== 32'hC || lat !== ref_lat(2'b00, 32'd2)) begin
      n_err++;
      $display("FAIL bp_next got rd=%h lat=%0d exp rd=0000000c lat=%0d",
               r, lat, ref_lat(2'b00, 32'd2));
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    int lat;
    int bad;
    int seen;
    req_valid = 1'b1;
    op = 2'b00;
    rs1 = 32'h00000ABC;
    rs2 = 32'd20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (resp_valid !== 1'b0 || rd !== 32'h0 || busy !== 1'b0 ||
        req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got vld=%b rd=%h busy=%b rdy=%b exp 0 0 0 0",
               resp_valid, rd, busy, req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_ready got=%b exp=1", req_ready);
    end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL mid_reset_no_resp got=%0d valid cycles exp=0", seen);
    end
    run_op(2'b01, 32'h80000000, 32'd4, 1'b1, r, lat, bad);
    n_vec++;
    if (r !== 32'h08000000 || lat !== ref_lat(2'b01, 32'd4) || bad !== 0) begin
      n_err++;
      $display("FAIL mid_reset_next got rd=%h lat=%0d bad=%0d exp rd=08000000 lat=%0d bad=0",
               r, lat, bad, ref_lat(2'b01, 32'd4));
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    op = 2'b00;
    rs1 = '0;
    rs2 = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
